// File: rtl/trigger_seq_core.sv
// Trigger sequencer: pops FIFO commands, syncs DAC/ADC channels, issues trigger pulses 1 cycle after the decision.
// Pop is combinational on head-valid and command-done; a head CANCEL pops in any non-error state.
module trigger_seq_core #(
  parameter int N_DAC                   = 8,
  parameter int N_ADC                   = 8,
  parameter int TRIGGER_LOCKOUT_DEFAULT = 5000,
  parameter int TRIG_PULSE_W            = 1,
  parameter int TIMEOUT_DEFAULT         = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             cmd_word_rd_en,
  input  logic [31:0]      cmd_word,
  input  logic             cmd_buf_empty,
  input  logic             ext_trigger,
  input  logic [N_DAC-1:0] dac_waiting_for_trigger,
  input  logic [N_ADC-1:0] adc_waiting_for_trigger,
  output logic             trigger_out,
  output logic [31:0]      trig_count,
  output logic             busy,
  output logic [2:0]       state_out,
  output logic             bad_cmd,
  output logic             timeout_err
);

  localparam int N_CH = N_DAC + N_ADC;
  localparam int PW   = $clog2(TRIG_PULSE_W + 1);

  localparam logic [2:0] OP_CANCEL  = 3'd1;
  localparam logic [2:0] OP_SYNC    = 3'd2;
  localparam logic [2:0] OP_LOCKOUT = 3'd3;
  localparam logic [2:0] OP_EXPECT  = 3'd4;
  localparam logic [2:0] OP_DELAY   = 3'd5;
  localparam logic [2:0] OP_FORCE   = 3'd6;
  localparam logic [2:0] OP_TIMEOUT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd1,
    S_SYNC   = 3'd2,
    S_EXPECT = 3'd3,
    S_DELAY  = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t          r_state;
  logic [N_CH-1:0] r_mask;
  logic [28:0]     r_lockout_val;
  logic [28:0]     r_timeout_val;
  logic [28:0]     r_lockout_cnt;
  logic [28:0]     r_timeout_cnt;
  logic [28:0]     r_delay_cnt;
  logic [28:0]     r_expect_cnt;
  logic [PW-1:0]   r_pulse_cnt;
  logic            r_ext_s;
  logic            r_ext_d;
  logic [31:0]     r_trig_count;
  logic            r_bad_cmd;
  logic            r_timeout_err;

  logic [2:0]      w_opcode;
  logic [28:0]     w_value;
  logic [N_CH-1:0] w_waiting;
  logic [N_CH-1:0] w_new_mask;
  logic            w_sync_ok;
  logic            w_new_sync_ok;
  logic            w_edge;
  logic            w_cancel;
  logic            w_cancel_pop;
  logic            w_ext_hit;
  logic            w_done;
  logic            w_in_wait;
  logic            w_completing;
  logic            w_timeout;
  logic            w_do_trig;
  logic            w_load_timeout;

  assign w_opcode      = cmd_word[31:29];
  assign w_value       = cmd_word[28:0];
  assign w_waiting     = {adc_waiting_for_trigger, dac_waiting_for_trigger};
  assign w_new_mask    = (w_value[N_CH-1:0] == '0) ? '1 : w_value[N_CH-1:0];
  assign w_sync_ok     = &(w_waiting | ~r_mask);
  assign w_new_sync_ok = &(w_waiting | ~w_new_mask);
  assign w_edge        = r_ext_s & ~r_ext_d;
  assign w_in_wait     = (r_state == S_SYNC) || (r_state == S_EXPECT);

  assign w_cancel  = !cmd_buf_empty && (w_opcode == OP_CANCEL) && (r_state != S_ERROR);
  assign w_ext_hit = (r_state == S_EXPECT) && (r_lockout_cnt == 29'd0) && w_edge &&
                     (r_expect_cnt != 29'd0) && !w_cancel;

  always_comb begin
    w_done = 1'b0;
    case (r_state)
      S_IDLE:   w_done = 1'b1;
      S_SYNC:   w_done = w_sync_ok;
      S_EXPECT: w_done = (r_expect_cnt == 29'd0);
      S_DELAY:  w_done = (r_delay_cnt == 29'd0);
      default:  w_done = 1'b0;
    endcase
  end

  assign cmd_word_rd_en = (r_state != S_ERROR) && !cmd_buf_empty && (w_done || w_cancel);
  assign w_cancel_pop   = cmd_word_rd_en && (w_opcode == OP_CANCEL);

  // A head CANCEL suppresses a SYNC that completes in the same cycle.
  assign w_do_trig = (cmd_word_rd_en && (w_opcode == OP_FORCE)) ||
                     (cmd_word_rd_en && (w_opcode == OP_SYNC) && w_new_sync_ok) ||
                     ((r_state == S_SYNC) && w_sync_ok && !w_cancel) ||
                     w_ext_hit;

  // Completion in the last timeout cycle takes precedence over the timeout.
  assign w_completing = ((r_state == S_SYNC) && w_sync_ok) ||
                        ((r_state == S_EXPECT) && ((r_expect_cnt == 29'd0) ||
                                                   (w_ext_hit && (r_expect_cnt == 29'd1))));
  assign w_timeout    = w_in_wait && (r_timeout_cnt == 29'd1) && !w_completing && !w_cancel;

  assign w_load_timeout = cmd_word_rd_en &&
                          (((w_opcode == OP_SYNC) && !w_new_sync_ok) ||
                           ((w_opcode == OP_EXPECT) && (w_value != 29'd0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mask        <= '1;
      r_lockout_val <= 29'(TRIGGER_LOCKOUT_DEFAULT);
      r_timeout_val <= 29'(TIMEOUT_DEFAULT);
      r_lockout_cnt <= '0;
      r_timeout_cnt <= '0;
      r_delay_cnt   <= '0;
      r_expect_cnt  <= '0;
      r_pulse_cnt   <= '0;
      r_ext_s       <= 1'b0;
      r_ext_d       <= 1'b0;
      r_trig_count  <= '0;
      r_bad_cmd     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ext_s <= ext_trigger;
      r_ext_d <= r_ext_s;

      if (w_do_trig) r_trig_count <= r_trig_count + 32'd1;

      if (w_cancel_pop)              r_pulse_cnt <= '0;
      else if (w_do_trig)            r_pulse_cnt <= PW'(TRIG_PULSE_W);
      else if (r_pulse_cnt != '0)    r_pulse_cnt <= r_pulse_cnt - PW'(1);

      if (w_cancel_pop)                  r_lockout_cnt <= '0;
      else if (w_ext_hit)                r_lockout_cnt <= r_lockout_val;
      else if (r_lockout_cnt != 29'd0)   r_lockout_cnt <= r_lockout_cnt - 29'd1;

      if (w_cancel_pop)                              r_timeout_cnt <= '0;
      else if (w_load_timeout)                       r_timeout_cnt <= r_timeout_val;
      else if (w_in_wait && r_timeout_cnt != 29'd0)  r_timeout_cnt <= r_timeout_cnt - 29'd1;

      if (w_cancel_pop)                                      r_delay_cnt <= '0;
      else if (cmd_word_rd_en && w_opcode == OP_DELAY)       r_delay_cnt <= w_value;
      else if (r_state == S_DELAY && r_delay_cnt != 29'd0)   r_delay_cnt <= r_delay_cnt - 29'd1;

      if (w_cancel_pop)                                 r_expect_cnt <= '0;
      else if (cmd_word_rd_en && w_opcode == OP_EXPECT) r_expect_cnt <= w_value;
      else if (w_ext_hit)                               r_expect_cnt <= r_expect_cnt - 29'd1;

      if (cmd_word_rd_en && w_opcode == OP_SYNC)    r_mask        <= w_new_mask;
      if (cmd_word_rd_en && w_opcode == OP_LOCKOUT) r_lockout_val <= w_value;
      if (cmd_word_rd_en && w_opcode == OP_TIMEOUT) r_timeout_val <= w_value;

      if (cmd_word_rd_en) begin
        case (w_opcode)
          OP_SYNC:   r_state <= w_new_sync_ok ? S_IDLE : S_SYNC;
          OP_EXPECT: r_state <= (w_value == 29'd0) ? S_IDLE : S_EXPECT;
          OP_DELAY:  r_state <= (w_value == 29'd0) ? S_IDLE : S_DELAY;
          3'd0: begin
            r_state   <= S_ERROR;
            r_bad_cmd <= 1'b1;
          end
          default:   r_state <= S_IDLE;
        endcase
      end else if (w_timeout) begin
        r_state       <= S_ERROR;
        r_timeout_err <= 1'b1;
      end else if (w_done) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign trigger_out = (r_pulse_cnt != '0) && (r_state != S_ERROR);
  assign trig_count  = r_trig_count;
  assign busy        = (r_state != S_IDLE);
  assign state_out   = r_state;
  assign bad_cmd     = r_bad_cmd;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_trigger_seq_core.sv
// Directed bench for trigger_seq_core with a queue-backed FWFT command FIFO model.
module tb_trigger_seq_core;

  logic        clk;
  logic        reset;
  logic        cmd_word_rd_en;
  logic [31:0] cmd_word;
  logic        cmd_buf_empty;
  logic        ext_trigger;
  logic [7:0]  dac_waiting_for_trigger;
  logic [7:0]  adc_waiting_for_trigger;
  logic        trigger_out;
  logic [31:0] trig_count;
  logic        busy;
  logic [2:0]  state_out;
  logic        bad_cmd;
  logic        timeout_err;

  trigger_seq_core #(
    .N_DAC(8), .N_ADC(8), .TRIGGER_LOCKOUT_DEFAULT(5000), .TRIG_PULSE_W(3), .TIMEOUT_DEFAULT(0)
  ) dut (
    .clk(clk), .reset(reset), .cmd_word_rd_en(cmd_word_rd_en), .cmd_word(cmd_word),
    .cmd_buf_empty(cmd_buf_empty), .ext_trigger(ext_trigger),
    .dac_waiting_for_trigger(dac_waiting_for_trigger),
    .adc_waiting_for_trigger(adc_waiting_for_trigger),
    .trigger_out(trigger_out), .trig_count(trig_count), .busy(busy), .state_out(state_out),
    .bad_cmd(bad_cmd), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [31:0] W_FORCE  = 32'hC000_0000;
  localparam logic [31:0] W_CANCEL = 32'h2000_0000;
  localparam logic [31:0] W_SYNC   = 32'h4000_0000;
  localparam logic [31:0] W_LOCK   = 32'h6000_0000;
  localparam logic [31:0] W_EXPECT = 32'h8000_0000;
  localparam logic [31:0] W_DELAY  = 32'hA000_0000;
  localparam logic [31:0] W_TMO    = 32'hE000_0000;

  logic [31:0] q[$];
  logic        rd_last;
  int          n_vec;
  int          n_err;
  int          rd_sum;
  logic [9:0]  rd_bits;
  logic [9:0]  tr_bits;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic head_upd();
    cmd_buf_empty = (q.size() == 0);
    cmd_word      = (q.size() != 0) ? q[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    head_upd();
  endtask

  // Called at posedge+1; samples the combinational pop mid-cycle, then retires it at the edge.
  task automatic cyc();
    #3;
    rd_last = cmd_word_rd_en;
    @(posedge clk);
    #1;
    if (rd_last && q.size() != 0) void'(q.pop_front());
    head_upd();
  endtask

  task automatic do_reset();
    q.delete();
    head_upd();
    ext_trigger = 1'b0;
    dac_waiting_for_trigger = '0;
    adc_waiting_for_trigger = '0;
    reset = 1'b1;
    #2;
    chk("rst_state", {29'd0, state_out}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_trig_out", {31'd0, trigger_out}, 32'd0);
    chk("rst_trig_count", trig_count, 32'd0);
    chk("rst_bad_cmd", {31'd0, bad_cmd}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_rd_en", {31'd0, cmd_word_rd_en}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rd_last = 1'b0;
    reset = 1'b0;
    #1;
    do_reset();

    // Back-to-back FORCE_TRIG: second pop restarts the 3-cycle pulse.
    push(W_FORCE);
    push(W_FORCE);
    for (int i = 0; i < 10; i++) begin
      cyc();
      rd_bits[i] = rd_last;
      tr_bits[i] = trigger_out;
    end
    chk("force_rd_pattern", {22'd0, rd_bits}, 32'h003);
    chk("force_pulse_pattern", {22'd0, tr_bits}, 32'h00F);
    chk("force_trig_count", trig_count, 32'd2);

    // SYNC mask 0x3 with DAC0/1 already waiting: immediate trigger.
    dac_waiting_for_trigger = 8'h03;
    push(W_SYNC | 32'h3);
    cyc();
    chk("sync_imm_rd", {31'd0, rd_last}, 32'd1);
    chk("sync_imm_state", {29'd0, state_out}, 32'd1);
    chk("sync_imm_trig_out", {31'd0, trigger_out}, 32'd1);
    chk("sync_imm_count", trig_count, 32'd3);
    repeat (4) cyc();
    chk("sync_imm_pulse_end", {31'd0, trigger_out}, 32'd0);

    // SYNC mask 0x3 with only DAC0 waiting: waits until DAC1 joins.
    dac_waiting_for_trigger = 8'h01;
    push(W_SYNC | 32'h3);
    cyc();
    chk("sync_wait_state", {29'd0, state_out}, 32'd2);
    cyc();
    chk("sync_wait_busy", {31'd0, busy}, 32'd1);
    chk("sync_wait_count", trig_count, 32'd3);
    dac_waiting_for_trigger = 8'h03;
    cyc();
    chk("sync_done_state", {29'd0, state_out}, 32'd1);
    chk("sync_done_count", trig_count, 32'd4);
    dac_waiting_for_trigger = 8'h00;
    repeat (4) cyc();

    // Lockout 10, expect 2 external edges.
    push(W_LOCK | 32'd10);
    push(W_EXPECT | 32'd2);
    cyc();
    cyc();
    chk("expect_state", {29'd0, state_out}, 32'd3);
    ext_trigger = 1'b1;
    repeat (3) cyc();
    chk("ext_first_edge", trig_count, 32'd5);
    ext_trigger = 1'b0;
    repeat (2) cyc();
    ext_trigger = 1'b1;
    repeat (30) cyc();
    chk("ext_lockout_and_level", trig_count, 32'd5);
    chk("ext_still_expect", {29'd0, state_out}, 32'd3);
    ext_trigger = 1'b0;
    repeat (2) cyc();
    ext_trigger = 1'b1;
    repeat (4) cyc();
    chk("ext_second_edge", trig_count, 32'd6);
    chk("ext_done_state", {29'd0, state_out}, 32'd1);
    ext_trigger = 1'b0;

    // Timeout 50 on SYNC with nothing waiting; trailing word must stay queued.
    push(W_TMO | 32'd50);
    push(W_SYNC);
    push(W_FORCE);
    cyc();
    cyc();
    chk("tmo_sync_state", {29'd0, state_out}, 32'd2);
    repeat (49) cyc();
    chk("tmo_last_sync_cycle", {29'd0, state_out}, 32'd2);
    cyc();
    chk("tmo_error_state", {29'd0, state_out}, 32'd5);
    chk("tmo_err_flag", {31'd0, timeout_err}, 32'd1);
    rd_sum = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      rd_sum += int'(rd_last);
    end
    chk("tmo_no_pop", rd_sum, 32'd0);
    chk("tmo_fifo_left", q.size(), 32'd1);
    chk("tmo_trig_count", trig_count, 32'd6);
    chk("tmo_bad_cmd", {31'd0, bad_cmd}, 32'd0);

    do_reset();

    // DELAY 1000 aborted by a CANCEL queued behind it.
    push(W_DELAY | 32'd1000);
    push(W_CANCEL);
    cyc();
    chk("delay_state", {29'd0, state_out}, 32'd4);
    cyc();
    chk("cancel_popped", {31'd0, rd_last}, 32'd1);
    chk("cancel_state", {29'd0, state_out}, 32'd1);
    chk("cancel_fifo_empty", q.size(), 32'd0);

    // CANCEL right after FORCE cuts the pulse but keeps the count.
    push(W_FORCE);
    push(W_CANCEL);
    cyc();
    chk("force_pulse_on", {31'd0, trigger_out}, 32'd1);
    cyc();
    chk("cancel_pulse_off", {31'd0, trigger_out}, 32'd0);
    chk("cancel_keeps_count", trig_count, 32'd1);

    // SYNC completing while CANCEL sits at the head: cancel wins.
    push(W_SYNC | 32'h3);
    cyc();
    chk("sync_cancel_wait", {29'd0, state_out}, 32'd2);
    dac_waiting_for_trigger = 8'h03;
    push(W_CANCEL);
    cyc();
    chk("sync_cancel_rd", {31'd0, rd_last}, 32'd1);
    chk("sync_cancel_state", {29'd0, state_out}, 32'd1);
    chk("sync_cancel_no_trig", trig_count, 32'd1);
    cyc();
    chk("sync_cancel_out_low", {31'd0, trigger_out}, 32'd0);
    dac_waiting_for_trigger = 8'h00;

    // Illegal opcode: terminal error, nothing else popped.
    push(32'h0000_0005);
    push(W_FORCE);
    cyc();
    chk("bad_pop", {31'd0, rd_last}, 32'd1);
    chk("bad_state", {29'd0, state_out}, 32'd5);
    chk("bad_flag", {31'd0, bad_cmd}, 32'd1);
    rd_sum = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      rd_sum += int'(rd_last);
    end
    chk("bad_no_pop", rd_sum, 32'd0);
    chk("bad_trig_count", trig_count, 32'd1);

    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_seq_core.md
Name: trigger_seq_core

Overview:
- Parametrised successor trigger sequencer for the LCB.
- Consumes 32-bit command words from a first-word-fall-through command FIFO.
- Generates a trigger pulse that synchronises N_DAC DAC channels and N_ADC ADC channels.
- Adds over the previous generation: masked channel sync, configurable pulse width, sync/expect timeout with error reporting, ext-trigger edge detection, a running trigger count, and a state/status readout.

Parameters:
- N_DAC, 8, DAC channel count (1..16).
- N_ADC, 8, ADC channel count (1..16); N_DAC+N_ADC must be <= 29.
- TRIGGER_LOCKOUT_DEFAULT, 5000, post-trigger lockout in cycles after reset.
- TRIG_PULSE_W, 1, trigger_out high time in cycles (>=1).
- TIMEOUT_DEFAULT, 0, sync/expect timeout in cycles after reset; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cmd_word_rd_en  out  1  pops the FIFO head (combinational).
- cmd_word  in  32  FIFO head; [31:29] opcode, [28:0] value.
- cmd_buf_empty  in  1  FIFO empty.
- ext_trigger  in  1  external trigger level, already synchronised to clk.
- dac_waiting_for_trigger  in  N_DAC  per-DAC waiting flags.
- adc_waiting_for_trigger  in  N_ADC  per-ADC waiting flags.
- trigger_out  out  1  trigger pulse.
- trig_count  out  32  triggers issued since reset; wraps 0xFFFFFFFF->0.
- busy  out  1  state != S_IDLE.
- state_out  out  3  current state encoding.
- bad_cmd  out  1  sticky: illegal opcode seen.
- timeout_err  out  1  sticky: sync/expect timed out.

Behaviour:
- Reset values (asynchronous): state=S_IDLE, all outputs 0, lockout=TRIGGER_LOCKOUT_DEFAULT, timeout=TIMEOUT_DEFAULT, mask=all ones, all counters 0.
- Opcodes:
  - 0 = illegal.
  - 1 CANCEL.
  - 2 SYNC_CH: value[N_DAC+N_ADC-1:0] is the channel mask, {adc,dac} order with DAC in the LSBs; mask 0 means all channels.
  - 3 SET_LOCKOUT.
  - 4 EXPECT_EXT_TRIG: value = trigger count.
  - 5 DELAY: value = cycles.
  - 6 FORCE_TRIG.
  - 7 SET_TIMEOUT.
- States: S_IDLE=1, S_SYNC=2, S_EXPECT=3, S_DELAY=4, S_ERROR=5.
- Command acceptance:
  - A command is popped (rd_en=1 for one cycle, combinational) when the FIFO is non-empty and the current command is done.
  - Done conditions: in IDLE always; in SYNC when all masked channels are waiting; in EXPECT when the remaining count is 0; in DELAY when the counter is 0.
- Transition by popped opcode:
  - CANCEL, SET_LOCKOUT, SET_TIMEOUT, FORCE_TRIG -> IDLE.
  - SYNC_CH -> IDLE if all masked channels are already waiting (trigger issued the same cycle), else SYNC.
  - EXPECT with value 0 -> IDLE, else EXPECT.
  - DELAY with value 0 -> IDLE, else DELAY.
  - Opcode 0 -> ERROR and set bad_cmd.
  - When FIFO is empty at done: -> IDLE.
- CANCEL priority:
  - A CANCEL at the FIFO head is popped in any non-ERROR state, even if the current command is not done.
  - It clears the delay, expect, lockout and timeout counters and the pulse counter (trigger_out low next cycle), then -> IDLE.
  - trig_count is not cleared.
- ext_trigger handling:
  - Registered internally; only a rising edge (ext=1 with previous sample 0) counts.
  - An edge counts only in EXPECT with lockout counter == 0.
  - Each counted edge decrements the remaining count and loads lockout.
  - The lockout counter also counts down outside EXPECT.
- Trigger pulse:
  - do_trigger sources: FORCE_TRIG pop, SYNC satisfied, counted ext edge.
  - trigger_out rises 1 cycle after do_trigger and stays high TRIG_PULSE_W cycles.
  - A new do_trigger during a pulse restarts the width count.
  - trig_count increments by 1 per do_trigger, registered.
- Timeout:
  - On entry to SYNC or EXPECT, load the timeout counter.
  - If the timeout is nonzero and the counter reaches 0 before the state completes -> ERROR and set timeout_err.
  - Counting is suspended in other states.
  - A trigger in the final timeout cycle wins over the timeout.
- ERROR state:
  - Terminal until reset: rd_en=0, trigger_out forced 0, no triggers, CANCEL ignored.
- Simultaneous events: SYNC completion and a head CANCEL in the same cycle -> the cancel wins and no trigger is issued.
- Reset mid-pulse or mid-command: immediate asynchronous return to reset values.

Test Plan:
- FIFO [6<<29, 6<<29] with TRIG_PULSE_W=3 -> two rd_en pulses on consecutive cycles; trigger_out high 4 contiguous cycles (restart behaviour); trig_count=2.
- SYNC_CH with mask 0x0003 and only DAC0/DAC1 waiting -> trigger 1 cycle after pop, state returns to IDLE; other channels' flags are ignored.
- SET_LOCKOUT 10, EXPECT 2, ext_trigger held high for 30 cycles, then toggled -> the first edge triggers; the held level does not retrigger; the next edge ≥10 cycles later triggers; state -> IDLE; trig_count=2.
- SET_TIMEOUT 50, SYNC_CH mask 0 with no channels waiting -> ERROR at cycle 50, timeout_err=1, subsequent FIFO words not popped.
- DELAY 1000 then CANCEL queued behind it -> CANCEL popped the cycle it reaches the FIFO head; state IDLE in the next cycle; delay aborted.
- Opcode 0 word -> bad_cmd=1, state_out=5, rd_en held 0; reset pulse -> all outputs 0, state_out=1.
